// File: rtl/ehgu_fifo_wr_ctrl.sv
// Burst write controller for the ehgu synchronous FIFO. It reserves space for a whole
// burst before accepting source words and tracks occupancy from consumer read credits.
module ehgu_fifo_wr_ctrl #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 128,
    parameter int unsigned BURST_LEN = 16,
    parameter int unsigned GAP_CYC   = 0,
    parameter int unsigned AF_LEVEL  = DEPTH - 4
) (
    input  logic                         clk0,
    input  logic                         rst,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [WIDTH-1:0]             s_data,
    input  logic                         credit,
    output logic                         en,
    output logic [WIDTH-1:0]             data_in,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         almost_full,
    output logic                         udf_err
);

    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned BW = $clog2(BURST_LEN + 1);
    localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [1:0] {StIdle, StBurst, StGap} state_e;

    state_e            state_q, state_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [LW-1:0]     level_q, level_d;
    logic              udf_q, udf_d;
    logic              en_q, en_d;
    logic [WIDTH-1:0]  data_q, data_d;

    logic              accept;
    logic [LW-1:0]     free_space;
    logic              space_ok;

    assign s_ready     = (state_q == StBurst);
    assign accept      = s_valid & s_ready;
    // Space check uses the registered level, so a same-cycle credit only makes it conservative.
    assign free_space  = LW'(DEPTH) - level_q;
    assign space_ok    = (free_space >= LW'(BURST_LEN));

    assign en          = en_q;
    assign data_in     = data_q;
    assign level       = level_q;
    assign full        = (level_q == LW'(DEPTH));
    assign almost_full = (level_q >= LW'(AF_LEVEL));
    assign udf_err     = udf_q;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        gap_d   = gap_q;
        level_d = level_q;
        udf_d   = udf_q;
        en_d    = 1'b0;
        data_d  = data_q;

        if (accept) begin
            en_d   = 1'b1;
            data_d = s_data;
        end

        if (accept && !credit) begin
            level_d = level_q + LW'(1);
        end else if (credit && !accept) begin
            if (level_q == '0) begin
                udf_d = 1'b1;
            end else begin
                level_d = level_q - LW'(1);
            end
        end

        unique case (state_q)
            StIdle: begin
                if (s_valid && space_ok) begin
                    state_d = StBurst;
                    beat_d  = '0;
                end
            end
            StBurst: begin
                if (accept) begin
                    if (beat_q == BW'(BURST_LEN - 1)) begin
                        beat_d  = '0;
                        gap_d   = '0;
                        state_d = (GAP_CYC > 0) ? StGap : StIdle;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            StGap: begin
                if (gap_q == GW'(GAP_CYC - 1)) begin
                    gap_d   = '0;
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk0 or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            beat_q  <= '0;
            gap_q   <= '0;
            level_q <= '0;
            udf_q   <= 1'b0;
            en_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            gap_q   <= gap_d;
            level_q <= level_d;
            udf_q   <= udf_d;
            en_q    <= en_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_ehgu_fifo_wr_ctrl.sv
// Bench for ehgu_fifo_wr_ctrl: two parameterisations share one stimulus stream and are
// checked every cycle against a rule-level model, plus directed literal checks.
module tb_ehgu_fifo_wr_ctrl;

    localparam int D0 = 128, B0 = 16, G0 = 0, A0 = 124;
    localparam int D1 = 16,  B1 = 4,  G1 = 3, A1 = 12;

    logic       clk0 = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic       credit = 1'b0;
    logic [7:0] s_data = 8'd0;

    logic       s_ready0, en0, full0, af0, udf0;
    logic [7:0] data_in0, level0;
    logic       s_ready1, en1, full1, af1, udf1;
    logic [7:0] data_in1;
    logic [4:0] level1;

    ehgu_fifo_wr_ctrl u0 (
        .clk0(clk0), .rst(rst), .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data),
        .credit(credit), .en(en0), .data_in(data_in0), .level(level0), .full(full0),
        .almost_full(af0), .udf_err(udf0)
    );

    ehgu_fifo_wr_ctrl #(.WIDTH(8), .DEPTH(D1), .BURST_LEN(B1), .GAP_CYC(G1), .AF_LEVEL(A1)) u1 (
        .clk0(clk0), .rst(rst), .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
        .credit(credit), .en(en1), .data_in(data_in1), .level(level1), .full(full1),
        .almost_full(af1), .udf_err(udf1)
    );

    always #5 clk0 = ~clk0;

    // mode: 0 waiting for space, 1 taking words, 2 forced idle
    typedef struct packed {
        logic [1:0] mode;
        logic [7:0] lvl;
        logic       udf;
        logic [7:0] left;
        logic       en;
        logic [7:0] din;
    } mdl_t;

    mdl_t m0, m1;
    int vectors = 0;
    int miscompares = 0;

    function automatic mdl_t step(input mdl_t m, input int depth, input int blen, input int gap,
                                  input logic sv, input logic [7:0] sd, input logic cr);
        mdl_t n;
        logic acc;
        n   = m;
        acc = sv && (m.mode == 2'd1);
        n.en = acc;
        if (acc) n.din = sd;
        if (acc && !cr) n.lvl = m.lvl + 8'd1;
        else if (cr && !acc) begin
            if (m.lvl == 8'd0) n.udf = 1'b1;
            else n.lvl = m.lvl - 8'd1;
        end
        case (m.mode)
            2'd0: if (sv && (depth - int'(m.lvl)) >= blen) begin
                n.mode = 2'd1;
                n.left = 8'(blen);
            end
            2'd1: if (acc) begin
                n.left = m.left - 8'd1;
                if (m.left == 8'd1) begin
                    n.mode = (gap > 0) ? 2'd2 : 2'd0;
                    n.left = 8'(gap);
                end
            end
            default: begin
                n.left = m.left - 8'd1;
                if (m.left == 8'd1) n.mode = 2'd0;
            end
        endcase
        return n;
    endfunction

    always @(posedge clk0 or posedge rst) begin
        if (rst) begin
            m0 <= '0;
            m1 <= '0;
        end else begin
            m0 <= step(m0, D0, B0, G0, s_valid, s_data, credit);
            m1 <= step(m1, D1, B1, G1, s_valid, s_data, credit);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic en1_h[64];
    logic rdy1_h[64];
    int   cyc = 0;
    logic [7:0] wr0[$];

    always @(negedge clk0) begin
        chk("u0.s_ready", int'(s_ready0), int'(m0.mode == 2'd1));
        chk("u0.en", int'(en0), int'(m0.en));
        chk("u0.data_in", int'(data_in0), int'(m0.din));
        chk("u0.level", int'(level0), int'(m0.lvl));
        chk("u0.full", int'(full0), int'(m0.lvl == 8'(D0)));
        chk("u0.almost_full", int'(af0), int'(m0.lvl >= 8'(A0)));
        chk("u0.udf_err", int'(udf0), int'(m0.udf));
        chk("u1.s_ready", int'(s_ready1), int'(m1.mode == 2'd1));
        chk("u1.en", int'(en1), int'(m1.en));
        chk("u1.data_in", int'(data_in1), int'(m1.din));
        chk("u1.level", int'(level1), int'(m1.lvl));
        chk("u1.full", int'(full1), int'(m1.lvl == 8'(D1)));
        chk("u1.almost_full", int'(af1), int'(m1.lvl >= 8'(A1)));
        chk("u1.udf_err", int'(udf1), int'(m1.udf));
        if (rst) begin
            cyc = 0;
            wr0.delete();
        end else begin
            if (cyc < 64) begin
                en1_h[cyc]  = en1;
                rdy1_h[cyc] = s_ready1;
            end
            cyc++;
            if (en0) wr0.push_back(data_in0);
        end
    end

    task automatic do_reset();
        @(negedge clk0);
        #2 rst = 1'b1;
        s_valid = 1'b0;
        credit  = 1'b0;
        s_data  = 8'd0;
        @(negedge clk0);
        #2 rst = 1'b0;
    endtask

    // Offer words to u0 until it has taken 'want'; optionally pair every accept with a credit.
    task automatic burst0(input int want, input bit with_credit, input bit count_data,
                          output int n);
        bit acc;
        n = 0;
        s_valid = 1'b1;
        for (int c = 0; c < 200 && n < want; c++) begin
            acc = s_ready0;
            credit = with_credit & s_ready0;
            @(negedge clk0);
            if (acc) begin
                n++;
                if (count_data) s_data = s_data + 8'd1;
            end
        end
        s_valid = 1'b0;
        credit  = 1'b0;
    endtask

    task automatic single_burst_test();
        int n, e, r, ones;
        do_reset();
        s_data = 8'h01;
        burst0(16, 1'b0, 1'b1, n);
        chk("t1 accepts", n, 16);
        repeat (3) @(negedge clk0);
        chk("t1 writes", wr0.size(), 16);
        for (int i = 0; i < 16 && i < wr0.size(); i++) chk("t1 word", int'(wr0[i]), i + 1);
        chk("t1 level", int'(level0), 16);
        chk("t1 idle", int'(s_ready0), 0);
        e = -1;
        for (int i = 0; i < 63; i++)
            if (e < 0 && en1_h[i] === 1'b1 && en1_h[i+1] === 1'b0) e = i;
        r = -1;
        for (int j = 0; j < 64; j++) if (r < 0 && j > e && rdy1_h[j] === 1'b1) r = j;
        ones = 0;
        for (int i = 0; i <= e && i < 64; i++) if (en1_h[i] === 1'b1) ones++;
        chk("u1 gap to next ready", r - e, 4);
        chk("u1 first burst writes", ones, 4);
    endtask

    initial begin
        int n;
        single_burst_test();

        // Fill u0 to full with no credits, then release space one credit at a time.
        s_valid = 1'b1;
        repeat (150) begin
            s_data = 8'($urandom);
            @(negedge clk0);
        end
        chk("fill level", int'(level0), 128);
        chk("fill full", int'(full0), 1);
        chk("fill ready", int'(s_ready0), 0);
        chk("fill writes", wr0.size(), 128);
        credit = 1'b1;
        repeat (15) @(negedge clk0);
        credit = 1'b0;
        repeat (3) @(negedge clk0);
        chk("15 credits ready", int'(s_ready0), 0);
        chk("15 credits level", int'(level0), 113);
        credit = 1'b1;
        @(negedge clk0);
        credit = 1'b0;
        @(negedge clk0);
        chk("16th credit ready", int'(s_ready0), 1);
        repeat (20) @(negedge clk0);
        s_valid = 1'b0;
        repeat (3) @(negedge clk0);

        // Accept and credit together from level 10.
        do_reset();
        burst0(16, 1'b0, 1'b0, n);
        credit = 1'b1;
        repeat (6) @(negedge clk0);
        credit = 1'b0;
        @(negedge clk0);
        chk("pre level", int'(level0), 10);
        burst0(16, 1'b1, 1'b1, n);
        repeat (2) @(negedge clk0);
        chk("acc+credit level", int'(level0), 10);
        chk("acc+credit writes", wr0.size(), 32);

        // Stall u1 mid-burst after two beats.
        do_reset();
        n = 0;
        s_valid = 1'b1;
        for (int c = 0; c < 50 && n < 2; c++) begin
            bit acc;
            acc = s_ready1;
            @(negedge clk0);
            if (acc) n++;
        end
        s_valid = 1'b0;
        repeat (5) begin
            @(negedge clk0);
            chk("stall ready", int'(s_ready1), 1);
            chk("stall en", int'(en1), 0);
        end
        n = 0;
        s_valid = 1'b1;
        for (int c = 0; c < 50 && n < 2; c++) begin
            bit acc;
            acc = s_ready1;
            @(negedge clk0);
            if (acc) n++;
        end
        s_valid = 1'b0;
        chk("stall resume beats", n, 2);
        repeat (2) @(negedge clk0);
        chk("stall level", int'(level1), 4);
        chk("stall done", int'(s_ready1), 0);
        repeat (6) @(negedge clk0);

        // Underflow, then asynchronous reset mid-burst.
        do_reset();
        credit = 1'b1;
        @(negedge clk0);
        credit = 1'b0;
        @(negedge clk0);
        chk("udf set", int'(udf0), 1);
        chk("udf level", int'(level0), 0);
        burst0(5, 1'b0, 1'b0, n);
        s_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("async en", int'(en0), 0);
        chk("async ready", int'(s_ready0), 0);
        chk("async level", int'(level0), 0);
        chk("async udf", int'(udf0), 0);
        s_valid = 1'b0;
        @(negedge clk0);
        #2 rst = 1'b0;
        single_burst_test();

        // Random traffic.
        do_reset();
        repeat (3000) begin
            @(negedge clk0);
            s_valid = ($urandom_range(0, 9) < 7);
            credit  = ($urandom_range(0, 9) < 4);
            s_data  = 8'($urandom);
        end
        s_valid = 1'b0;
        credit  = 1'b0;
        repeat (2) @(negedge clk0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
